// File: rtl/payload_match_reporter.sv
// Snapshots the engine match flags one cycle after end of payload and streams
// the set bits out as rule IDs, lowest first, with one shadow snapshot buffered.
module payload_match_reporter #(
  parameter int NUM_ENGINES = 64,
  parameter int ID_WIDTH    = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_WIDTH-1:0]    rpt_id,
  output logic                   rpt_none,
  output logic                   rpt_last,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [NUM_ENGINES-1:0] ONE = NUM_ENGINES'(1);

  state_t                 state_reg, state_next;
  logic                   cap_reg;
  logic [NUM_ENGINES-1:0] act_reg, act_next;
  logic [NUM_ENGINES-1:0] shd_reg, shd_next;
  logic                   shd_v_reg, shd_v_next;
  logic [CNT_WIDTH-1:0]   pkt_count_reg, drop_count_reg;
  logic                   overflow_reg;

  logic                   act_v;
  logic [NUM_ENGINES-1:0] act_rest;
  logic [ID_WIDTH-1:0]    low_id;
  logic                   fire, act_free, drop;

  assign act_v    = (state_reg == SEND);
  // act with its lowest set bit cleared; zero means this is the final beat
  assign act_rest = act_reg & (act_reg - ONE);
  assign fire     = act_v & rpt_ready;
  assign act_free = ~act_v | (fire & rpt_last);

  always_comb begin
    low_id = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (act_reg[i]) low_id = ID_WIDTH'(i);
    end
  end

  assign rpt_valid  = act_v;
  assign rpt_id     = low_id;
  assign rpt_none   = act_v & (act_reg == '0);
  assign rpt_last   = act_v & (act_rest == '0);
  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;
  assign overflow   = overflow_reg;

  always_comb begin
    state_next = state_reg;
    act_next   = act_reg;
    shd_next   = shd_reg;
    shd_v_next = shd_v_reg;
    drop       = 1'b0;
    if (fire) act_next = act_rest;
    if (act_free) begin
      // the older shadow packet always goes out before a newly captured one
      if (shd_v_reg) begin
        act_next   = shd_reg;
        state_next = SEND;
        shd_v_next = cap_reg;
        if (cap_reg) shd_next = match_in;
      end else if (cap_reg) begin
        act_next   = match_in;
        state_next = SEND;
      end else begin
        state_next = IDLE;
      end
    end else if (cap_reg) begin
      if (!shd_v_reg) begin
        shd_next   = match_in;
        shd_v_next = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cap_reg        <= 1'b0;
      act_reg        <= '0;
      shd_reg        <= '0;
      shd_v_reg      <= 1'b0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cap_reg   <= eod & en;
      act_reg   <= act_next;
      shd_reg   <= shd_next;
      shd_v_reg <= shd_v_next;
      if (cap_reg) pkt_count_reg <= pkt_count_reg + 1'b1;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + 1'b1;
      end
    end
  end

endmodule

// File: doc/payload_match_reporter.md
# payload_match_reporter

Downstream collector for the payload engine array. Each engine drives a sticky one-bit match flag that the engine clears on `sod`. This block snapshots all flags at end of payload and serialises the set bits as rule IDs over a valid/ready stream, lowest index first. It holds one snapshot in service and one in a shadow buffer; further snapshots are dropped and counted.

## Interface
- `NUM_ENGINES`, 64: number of engine match flags.
- `ID_WIDTH`, 6: width of a reported rule ID; must satisfy 2^ID_WIDTH >= NUM_ENGINES.
- `CNT_WIDTH`, 16: width of the packet and drop counters.
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  byte-valid strobe, the same one fed to the engines.
- `eod`  in  1  last payload byte of a packet; honoured only when `en`=1.
- `match_in`  in  NUM_ENGINES  engine `out` flags; bit i is engine i.
- `rpt_valid`  out  1  report beat valid.
- `rpt_ready`  in  1  consumer accepts the beat.
- `rpt_id`  out  ID_WIDTH  rule ID (engine index) of this beat.
- `rpt_none`  out  1  packet had no match; `rpt_id`=0 on this beat.
- `rpt_last`  out  1  final beat of this packet's report.
- `pkt_count`  out  CNT_WIDTH  snapshots taken; wraps modulo 2^CNT_WIDTH.
- `drop_count`  out  CNT_WIDTH  snapshots dropped; saturates at all-ones.
- `overflow`  out  1  sticky; set on the first drop, cleared only by `rst`.

## Operation
- Capture trigger: an internal `cap` register loads `eod & en` every cycle.
  - Engine flags are registered, so the last byte's result becomes visible one cycle after `eod`.
  - When `cap`=1, `match_in` is snapshotted. `en` does not gate the snapshot cycle.
- Storage: an active register `act` with flag `act_v`, and a shadow register `shd` with flag `shd_v`.
- On a snapshot:
  - `act` is free (`act_v`=0, or its last beat is being accepted this cycle): load `act`.
  - Otherwise `shd_v`=0: load `shd`.
  - Otherwise: drop the snapshot, increment `drop_count` (saturating) and set `overflow`.
  - `pkt_count` increments on every snapshot, including dropped ones.
- Priority order when `act` is freed and a snapshot arrives in the same cycle:
  - If `shd_v`=1, `shd` moves to `act` and the new snapshot is written to `shd`.
  - Otherwise the new snapshot goes directly to `act`.
  - The promoted shadow packet always precedes the newer packet.
- States: IDLE (`act_v`=0) and SEND (`act_v`=1).
  - In SEND, `rpt_id` is the index of the lowest set bit of `act`.
  - `rpt_last`=1 when exactly one bit remains set.
  - On a handshake (`rpt_valid & rpt_ready`), that bit is cleared.
  - After the last beat, go to IDLE, or stay in SEND if `shd` is promoted or a snapshot is loaded that cycle.
- Empty snapshot (all zeros): produces exactly one beat with `rpt_none`=1, `rpt_id`=0, `rpt_last`=1.
- `match_in` bits at or above `NUM_ENGINES` do not exist; IDs never exceed `NUM_ENGINES`-1.
- `sod` is not an input. Engines clear themselves; `act` and `shd` are unaffected by a new packet starting.

## Timing
- Reset values: `rpt_valid`=0, `rpt_id`=0, `rpt_none`=0, `rpt_last`=0, `pkt_count`=0, `drop_count`=0, `overflow`=0, `act_v`=0, `shd_v`=0, `cap`=0.
- `eod & en` sampled at edge T → `cap`=1 during cycle T+1 → snapshot loaded at edge T+2 → `rpt_valid`=1 from cycle T+2.
- `rpt_id`, `rpt_none` and `rpt_last` are registered or derived only from `act`; they have no combinational path from `match_in`.
- While `rpt_valid`=1 and `rpt_ready`=0, all `rpt_*` outputs hold stable.
- Throughput is one beat per cycle when `rpt_ready`=1, including back-to-back packets; there is no idle bubble when `shd` is promoted.
- `rst` mid-report: outputs drop to reset values asynchronously, all pending snapshots are discarded, and no partial beat is emitted after release.

## Test plan
- Single packet: flags {3, 17, 40} set, `eod` pulsed, `rpt_ready`=1 → beats with IDs 3, 17, 40 on three consecutive cycles starting 2 cycles after `eod`; `rpt_last` on 40; `pkt_count`=1.
- Empty packet: `match_in`=0 at snapshot → one beat with `rpt_none`=1, `rpt_id`=0, `rpt_last`=1.
- Backpressure: flags {0, 63}, `rpt_ready` low for 5 cycles → ID 0 held stable for 5 cycles, then IDs 0 and 63 in order.
- Shadow and overflow: `rpt_ready`=0, three packets end with flags {1}, {2}, {5} → reports for 1 and 2 only; `drop_count`=1, `overflow`=1, `pkt_count`=3.
- Simultaneous free and capture: last beat of packet A (ID 9) accepted in the same cycle the snapshot for B {4} loads, `shd` empty → next cycle shows ID 4 with no gap.
- Reset mid-report: flags {2, 7, 11}, assert `rst` after ID 2 is accepted → `rpt_valid`=0 immediately, all counters 0, no further beats.
